// File: rtl/player_pkg.sv
// Shared types and constants for the player sprite path: state encoding,
// sprite geometry, movement bit indices and the draw_player clamp rule.
package player_pkg;

  localparam int unsigned SPRITE_W  = 8;
  localparam int unsigned SPRITE_H  = 8;
  localparam int unsigned X_W       = 8;
  localparam int unsigned Y_W       = 7;
  localparam int unsigned C_W       = 3;
  localparam int unsigned MV_W      = 4;
  localparam int unsigned UP        = 0;
  localparam int unsigned DOWN      = 1;
  localparam int unsigned LEFT      = 2;
  localparam int unsigned RIGHT     = 3;
  localparam int unsigned X_MAX_DEF = 152;
  localparam int unsigned Y_MAX_DEF = 112;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ERASE,
    S_REQ,
    S_REL
  } state_t;

  // One-step move with clamping; opposing keys together cancel.
  function automatic logic [X_W-1:0] clamp_step(input logic [X_W-1:0] pos,
                                                input logic inc,
                                                input logic dec,
                                                input logic [X_W-1:0] lim);
    if (inc && !dec && pos < lim) return pos + X_W'(1);
    if (dec && !inc && pos != '0) return pos - X_W'(1);
    return pos;
  endfunction

endpackage

// File: rtl/sprite_fill.sv
// 8x8 rectangle scanner: on start, emits one pixel per cycle in row-major
// order from the given origin; done marks the final pixel.
module sprite_fill
  import player_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [X_W-1:0] origin_x,
  input  logic [Y_W-1:0] origin_y,
  input  logic [C_W-1:0] colour,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [C_W-1:0] pixel_colour,
  output logic           plot,
  output logic           done
);

  localparam int unsigned EX_W = $clog2(SPRITE_W);
  localparam int unsigned EY_W = $clog2(SPRITE_H);

  logic [EX_W-1:0] ex;
  logic [EY_W-1:0] ey;
  logic [X_W-1:0]  base_x;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex           <= '0;
      ey           <= '0;
      base_x       <= '0;
      x            <= '0;
      y            <= '0;
      pixel_colour <= '0;
      plot         <= 1'b0;
      done         <= 1'b0;
    end else if (start) begin
      ex           <= '0;
      ey           <= '0;
      base_x       <= origin_x;
      x            <= origin_x;
      y            <= origin_y;
      pixel_colour <= colour;
      plot         <= 1'b1;
      done         <= 1'b0;
    end else if (plot) begin
      if (ex == EX_W'(SPRITE_W - 1)) begin
        ex <= '0;
        x  <= base_x;
        if (ey == EY_W'(SPRITE_H - 1)) begin
          plot <= 1'b0;
        end else begin
          ey <= ey + EY_W'(1);
          y  <= y + Y_W'(1);
        end
      end else begin
        ex <= ex + EX_W'(1);
        x  <= x + X_W'(1);
      end
      // Flag the cycle that presents the last pixel of the rectangle.
      done <= (ex == EX_W'(SPRITE_W - 2)) && (ey == EY_W'(SPRITE_H - 1));
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/player_frame_ctrl.sv
// Per-frame sequencer ahead of draw_player: samples keys on the frame tick,
// erases the old sprite footprint, then runs the begin_draw/done handshake.
module player_frame_ctrl
  import player_pkg::*;
#(
  parameter int unsigned    FRAME_CYCLES = 833333,
  parameter int unsigned    X_INIT       = 76,
  parameter int unsigned    Y_INIT       = 90,
  parameter int unsigned    X_MAX        = X_MAX_DEF,
  parameter int unsigned    Y_MAX        = Y_MAX_DEF,
  parameter logic [C_W-1:0] BG_COLOUR    = 3'b000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            key_up,
  input  logic            key_down,
  input  logic            key_left,
  input  logic            key_right,
  output logic            begin_draw,
  output logic [MV_W-1:0] movement,
  input  logic            dp_done,
  input  logic [X_W-1:0]  dp_x,
  input  logic [Y_W-1:0]  dp_y,
  input  logic [C_W-1:0]  dp_colour,
  input  logic            dp_plot,
  output logic [X_W-1:0]  vga_x,
  output logic [Y_W-1:0]  vga_y,
  output logic [C_W-1:0]  vga_colour,
  output logic            vga_plot,
  output logic            overrun
);

  localparam int unsigned CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;

  state_t          state;
  logic [CNT_W-1:0] frame_cnt;
  logic            tick;
  logic [MV_W-1:0] key_meta, key_sync, mv;
  logic [X_W-1:0]  pos_x;
  logic [Y_W-1:0]  pos_y;
  logic [X_W-1:0]  fill_x;
  logic [Y_W-1:0]  fill_y;
  logic [C_W-1:0]  fill_colour;
  logic            fill_plot, fill_done;

  assign tick = (frame_cnt == CNT_W'(FRAME_CYCLES - 1));

  // Free-running frame timer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     frame_cnt <= '0;
    else if (tick) frame_cnt <= '0;
    else           frame_cnt <= frame_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_meta <= '0;
      key_sync <= '0;
    end else begin
      key_meta <= {key_right, key_left, key_down, key_up};
      key_sync <= key_meta;
    end
  end

  sprite_fill u_erase (
    .clk          (clk),
    .reset        (reset),
    .start        (tick && (state == S_IDLE)),
    .origin_x     (pos_x),
    .origin_y     (pos_y),
    .colour       (BG_COLOUR),
    .x            (fill_x),
    .y            (fill_y),
    .pixel_colour (fill_colour),
    .plot         (fill_plot),
    .done         (fill_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      begin_draw <= 1'b0;
      movement   <= '0;
      overrun    <= 1'b0;
      mv         <= '0;
      pos_x      <= X_W'(X_INIT);
      pos_y      <= Y_W'(Y_INIT);
    end else begin
      // Ticks that land mid-sequence are dropped but remembered.
      if (tick && state != S_IDLE) overrun <= 1'b1;
      case (state)
        S_IDLE: begin
          if (tick) begin
            mv    <= key_sync;
            state <= S_ERASE;
          end
        end
        S_ERASE: begin
          if (fill_done) begin
            state      <= S_REQ;
            begin_draw <= 1'b1;
            movement   <= mv;
            pos_x      <= clamp_step(pos_x, mv[RIGHT], mv[LEFT], X_W'(X_MAX));
            pos_y      <= Y_W'(clamp_step(X_W'(pos_y), mv[DOWN], mv[UP], X_W'(Y_MAX)));
          end
        end
        S_REQ: begin
          if (dp_done) begin
            begin_draw <= 1'b0;
            state      <= S_REL;
          end
        end
        S_REL: begin
          if (!dp_done) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // The erase engine owns the bus only while erasing; otherwise draw_player passes through.
  always_comb begin
    vga_x      = dp_x;
    vga_y      = dp_y;
    vga_colour = dp_colour;
    vga_plot   = dp_plot;
    if (state == S_ERASE) begin
      vga_x      = fill_x;
      vga_y      = fill_y;
      vga_colour = fill_colour;
      vga_plot   = fill_plot;
    end
  end

endmodule

// File: doc/player_frame_ctrl.md
Name: player_frame_ctrl

Overview:
- Per-frame sequencer directly upstream of the player sprite drawer (draw_player).
- On each frame tick it samples the direction keys, erases the sprite's previous 8x8 footprint with background colour, then issues the begin_draw/done handshake that makes draw_player move and redraw.
- Owns the VGA plot bus: drives erase pixels itself, otherwise passes draw_player's pixel outputs through.

Parameters:
- FRAME_CYCLES, 833333, clk cycles per frame tick (60 Hz at 50 MHz).
- X_INIT, 76, initial sprite x; must match draw_player.
- Y_INIT, 90, initial sprite y; must match draw_player.
- X_MAX, 152, largest legal sprite x.
- Y_MAX, 112, largest legal sprite y.
- BG_COLOUR, 3'b000, erase colour.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- key_up / key_down / key_left / key_right  in  1 each  raw held-key levels, asynchronous
- begin_draw  out  1  request to draw_player
- movement  out  4  [0]=up, [1]=down, [2]=left, [3]=right; to draw_player
- dp_done  in  1  draw_player done
- dp_x  in  8  draw_player pixel x
- dp_y  in  7  draw_player pixel y
- dp_colour  in  3  draw_player pixel colour
- dp_plot  in  1  draw_player drawEn
- vga_x  out  8  to VGA adapter
- vga_y  out  7  to VGA adapter
- vga_colour  out  3  to VGA adapter
- vga_plot  out  1  to VGA adapter
- overrun  out  1  sticky: a frame tick arrived while busy

Behaviour:
- Reset values:
  - state=IDLE; begin_draw=0; movement=0; overrun=0; frame counter=0.
  - pos_x=X_INIT, pos_y=Y_INIT; key synchronisers cleared.
- Key inputs: each key passes through a 2-flop synchroniser.
- Frame counter: counts 0..FRAME_CYCLES-1 and wraps. tick is high for one cycle at wrap. It free-runs in every state.
- IDLE: on tick, latch mv = {right,left,down,up} from the synchronised keys, then go to ERASE.
- ERASE: 64 cycles with vga_plot=1 and vga_colour=BG_COLOUR.
  - Scan is row-major: ex 0..7 inner, ey 0..7 outer.
  - vga_x = pos_x+ex; vga_y = pos_y+ey.
  - After pixel (7,7), go to REQ.
- REQ: drive begin_draw=1 and movement=mv. begin_draw stays high until dp_done=1, then go to REL.
  - On entry to REQ (one cycle), update the tracked position using draw_player's clamp rule:
    - Right only (mv[3]&~mv[2]) and pos_x<X_MAX: pos_x+1.
    - Left only (mv[2]&~mv[3]) and pos_x>0: pos_x-1.
    - Same rule for y: mv[1] means down (+1), bounded by Y_MAX; mv[0] means up (-1), bounded by 0.
    - Both opposing keys pressed: no change on that axis.
- REL: begin_draw=0; movement holds. When dp_done=0, go to IDLE.
- Bus mux: in ERASE, the erase engine drives the VGA bus. In every other state, vga_* = dp_* combinationally, with no added latency.
- Overrun: tick while state≠IDLE sets overrun (sticky until reset). That tick is dropped, not queued.
- Keys changing after the latch point have no effect until the next tick.
- Reset mid-operation:
  - Everything returns to its reset values; begin_draw drops at once.
  - Any draw in flight finishes in draw_player and is passed through to the VGA bus.
  - The first tick arrives FRAME_CYCLES after reset, which is far longer than a draw (about 200 cycles), so no guard state is needed.
  - draw_player has no reset, so the tracked position is coherent only at power-on or a board-level reset common to both blocks.
- Arithmetic widths: pos_x+ex is 8-bit, pos_y+ey is 7-bit, and neither can overflow given the X_MAX/Y_MAX bounds.

Decomposition:
- Shared package (player_pkg): state encoding; SPRITE_W=8, SPRITE_H=8; the movement bit indices (UP=0, DOWN=1, LEFT=2, RIGHT=3); X_MAX/Y_MAX defaults.
- One natural sub-module, sprite_fill: an 8x8 rectangle scanner. Inputs: start, origin, colour. Outputs: x, y, plot, done. It is reused later for enemy and bullet erase.

Test Plan (FRAME_CYCLES=100; draw_player model replies done 192 cycles after begin_draw):
1. Reset, no keys → first tick at cycle 100; ERASE plots exactly 64 pixels at (76..83, 90..97) with colour 0; then begin_draw=1, movement=0000; pos stays (76,90).
2. key_right held → movement=1000; pos_x goes 76→77→78 over successive completed frames; the ERASE origin of each frame equals the prior pos.
3. Start at x=152 (preload via 76 right-frames) with right held → pos_x stays 152; left+right together → no x change.
4. Ticks while busy (draw longer than 100 cycles) → overrun=1 and stays 1; the tick is dropped; no second ERASE starts until the handshake returns to IDLE.
5. Handshake: begin_draw stays high until dp_done=1, then drops the next cycle; the controller remains in REL while dp_done stays 1 for 5 cycles, and the next tick only proceeds after dp_done=0.
6. Reset asserted mid-ERASE → vga_plot drops immediately, begin_draw=0, pos=(76,90), overrun=0; passthrough of dp_plot resumes.
